// File: rtl/mult_seq_engine.sv
// Sequential repeated-addition multiplier: the product is built by adding the multiplicand MULT_REG times.
// Optional macro MULT_OPERAND_SWAP_EN puts the smaller operand in the multiplier, which shortens latency.
module mult_seq_engine #(
    parameter int WIDTH = 3
) (
    input  logic                 SYS_CLOCK,
    input  logic                 SYS_RESET,
    input  logic                 START,
    input  logic [WIDTH-1:0]     A,
    input  logic [WIDTH-1:0]     B,
    output logic                 BUSY,
    output logic                 DONE,
    output logic [2*WIDTH-1:0]   F_REG
);

    typedef enum logic {
        ST_IDLE = 1'b0,
        ST_ADD  = 1'b1
    } state_t;

    state_t               r_state;
    state_t               w_state_next;
    logic [WIDTH-1:0]     r_mcand;
    logic [WIDTH-1:0]     w_mcand_next;
    logic [WIDTH-1:0]     r_mult;
    logic [WIDTH-1:0]     w_mult_next;
    logic [WIDTH-1:0]     r_cnt;
    logic [WIDTH-1:0]     w_cnt_next;
    logic [2*WIDTH-1:0]   r_acc;
    logic [2*WIDTH-1:0]   w_acc_next;
    logic [2*WIDTH-1:0]   r_f;
    logic [2*WIDTH-1:0]   w_f_next;
    logic                 r_done;
    logic                 w_done_next;
    logic [WIDTH-1:0]     w_sel_mcand;
    logic [WIDTH-1:0]     w_sel_mult;

`ifdef MULT_OPERAND_SWAP_EN
    logic w_a_lt_b;
    assign w_a_lt_b    = (A < B);
    // On a tie B stays the multiplier.
    assign w_sel_mult  = w_a_lt_b ? A : B;
    assign w_sel_mcand = w_a_lt_b ? B : A;
`else
    assign w_sel_mult  = B;
    assign w_sel_mcand = A;
`endif

    always_ff @(posedge SYS_CLOCK) begin
        if (SYS_RESET) begin
            r_state <= ST_IDLE;
            r_mcand <= '0;
            r_mult  <= '0;
            r_cnt   <= '0;
            r_acc   <= '0;
            r_f     <= '0;
            r_done  <= 1'b0;
        end else begin
            r_state <= w_state_next;
            r_mcand <= w_mcand_next;
            r_mult  <= w_mult_next;
            r_cnt   <= w_cnt_next;
            r_acc   <= w_acc_next;
            r_f     <= w_f_next;
            r_done  <= w_done_next;
        end
    end

    always_comb begin
        w_state_next = r_state;
        w_mcand_next = r_mcand;
        w_mult_next  = r_mult;
        w_cnt_next   = r_cnt;
        w_acc_next   = r_acc;
        w_f_next     = r_f;
        w_done_next  = 1'b0;
        case (r_state)
            ST_IDLE: begin
                if (START) begin
                    w_mcand_next = w_sel_mcand;
                    w_mult_next  = w_sel_mult;
                    w_cnt_next   = '0;
                    w_acc_next   = '0;
                    w_state_next = ST_ADD;
                end
            end
            ST_ADD: begin
                // CNT stops at MULT_REG, so it can never wrap.
                if (r_cnt == r_mult) begin
                    w_f_next     = r_acc;
                    w_done_next  = 1'b1;
                    w_state_next = ST_IDLE;
                end else begin
                    w_acc_next = r_acc + {{WIDTH{1'b0}}, r_mcand};
                    w_cnt_next = r_cnt + 1'b1;
                end
            end
            default: w_state_next = ST_IDLE;
        endcase
    end

    assign BUSY  = (r_state != ST_IDLE);
    assign DONE  = r_done;
    assign F_REG = r_f;

endmodule

// File: tb/tb_mult_seq_engine.sv
// Directed self-checking bench for mult_seq_engine; one line per transaction.
module tb_mult_seq_engine;

`ifdef MULT_OPERAND_SWAP_EN
    localparam int W = 4;
`else
    localparam int W = 3;
`endif

    logic             clk;
    logic             srst;
    logic             start;
    logic [W-1:0]     a;
    logic [W-1:0]     b;
    logic             busy;
    logic             done;
    logic [2*W-1:0]   f_reg;

    int checks;
    int failures;

    mult_seq_engine #(.WIDTH(W)) dut (
        .SYS_CLOCK (clk),
        .SYS_RESET (srst),
        .START     (start),
        .A         (a),
        .B         (b),
        .BUSY      (busy),
        .DONE      (done),
        .F_REG     (f_reg)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        srst  = 1'b1;
        start = 1'b1;
        a     = W'(5);
        b     = W'(3);
        step();
        step();
        checks++;
        if (busy !== 1'b0) begin failures++; $display("FAIL reset_busy: got %0b expected 0", busy); end
        checks++;
        if (done !== 1'b0) begin failures++; $display("FAIL reset_done: got %0b expected 0", done); end
        checks++;
        if (f_reg !== '0) begin failures++; $display("FAIL reset_f: got %0d expected 0", f_reg); end
        start = 1'b0;
        srst  = 1'b0;
        step();
        checks++;
        if (busy !== 1'b0) begin failures++; $display("FAIL reset_no_start: busy got %0b expected 0", busy); end
        $display("reset: busy=%0b done=%0b f=%0d", busy, done, f_reg);
    endtask

    // Accept one operation and wait for DONE, checking latency, product and BUSY.
    task automatic test_op(input int av, input int bv, input int exp_f, input int exp_lat);
        int k;
        logic [2*W-1:0] f_seen;
        a     = W'(av);
        b     = W'(bv);
        start = 1'b1;
        step();
        start = 1'b0;
        a     = '0;
        b     = '0;
        checks++;
        if (busy !== 1'b1) begin failures++; $display("FAIL op_busy_after_accept %0dx%0d: got %0b expected 1", av, bv, busy); end
        k = 0;
        while (k < 64) begin
            step();
            k++;
            if (done === 1'b1) break;
        end
        f_seen = f_reg;
        checks++;
        if (k !== exp_lat) begin failures++; $display("FAIL op_latency %0dx%0d: got %0d expected %0d", av, bv, k, exp_lat); end
        checks++;
        if (f_reg !== (2*W)'(exp_f)) begin failures++; $display("FAIL op_product %0dx%0d: got %0d expected %0d", av, bv, f_reg, exp_f); end
        checks++;
        if (busy !== 1'b0) begin failures++; $display("FAIL op_busy_in_done %0dx%0d: got %0b expected 0", av, bv, busy); end
        step();
        checks++;
        if (done !== 1'b0) begin failures++; $display("FAIL op_done_pulse %0dx%0d: got %0b expected 0", av, bv, done); end
        checks++;
        if (f_reg !== (2*W)'(exp_f)) begin failures++; $display("FAIL op_hold %0dx%0d: got %0d expected %0d", av, bv, f_reg, exp_f); end
        $display("op %0dx%0d: latency=%0d f=%0d", av, bv, k, f_seen);
    endtask

    task automatic test_back_to_back();
        a     = W'(2);
        b     = W'(2);
        start = 1'b1;
        step();                 // accept 2x2
        a = W'(3);
        b = W'(1);
        step();
        step();
        step();                 // DONE of first
        checks++;
        if (done !== 1'b1) begin failures++; $display("FAIL b2b_done1: got %0b expected 1", done); end
        checks++;
        if (f_reg !== (2*W)'(4)) begin failures++; $display("FAIL b2b_f1: got %0d expected 4", f_reg); end
        step();                 // accept 3x1 in the DONE cycle
        checks++;
        if (busy !== 1'b1) begin failures++; $display("FAIL b2b_second_accept: busy got %0b expected 1", busy); end
        checks++;
        if (done !== 1'b0) begin failures++; $display("FAIL b2b_done_cleared: got %0b expected 0", done); end
        start = 1'b0;
        step();
        step();                 // DONE of second
        checks++;
        if (done !== 1'b1) begin failures++; $display("FAIL b2b_done2: got %0b expected 1", done); end
        checks++;
        if (f_reg !== (2*W)'(3)) begin failures++; $display("FAIL b2b_f2: got %0d expected 3", f_reg); end
        $display("back_to_back: f=%0d done=%0b", f_reg, done);
        step();
    endtask

    task automatic test_start_ignored();
        int k;
        a     = W'(6);
        b     = W'(4);
        start = 1'b1;
        step();
        start = 1'b0;
        step();
        step();
        a     = W'(1);
        b     = W'(1);
        start = 1'b1;
        step();
        start = 1'b0;
        k = 3;
        while (k < 64) begin
            step();
            k++;
            if (done === 1'b1) break;
        end
        checks++;
        if (k !== 5) begin failures++; $display("FAIL ignore_latency: got %0d expected 5", k); end
        checks++;
        if (f_reg !== (2*W)'(24)) begin failures++; $display("FAIL ignore_product: got %0d expected 24", f_reg); end
        $display("start_ignored: latency=%0d f=%0d", k, f_reg);
        step();
    endtask

    task automatic test_reset_mid_add();
        int saw_done;
        a     = W'(6);
        b     = W'(4);
        start = 1'b1;
        step();                 // edge 0
        start = 1'b0;
        step();                 // edge 1
        srst = 1'b1;
        step();                 // edge 2
        srst = 1'b0;
        checks++;
        if (busy !== 1'b0) begin failures++; $display("FAIL midrst_busy: got %0b expected 0", busy); end
        checks++;
        if (f_reg !== '0) begin failures++; $display("FAIL midrst_f: got %0d expected 0", f_reg); end
        saw_done = 0;
        for (int i = 0; i < 8; i++) begin
            step();
            if (done === 1'b1) saw_done = 1;
        end
        checks++;
        if (saw_done !== 0) begin failures++; $display("FAIL midrst_no_done: got %0d expected 0", saw_done); end
        checks++;
        if (busy !== 1'b0) begin failures++; $display("FAIL midrst_idle: busy got %0b expected 0", busy); end
        $display("reset_mid_add: busy=%0b f=%0d saw_done=%0d", busy, f_reg, saw_done);
    endtask

    initial begin
        checks   = 0;
        failures = 0;
        srst     = 1'b0;
        start    = 1'b0;
        a        = '0;
        b        = '0;
        test_reset();
`ifdef MULT_OPERAND_SWAP_EN
        test_op(15, 1, 15, 2);
        test_op(3, 3, 9, 4);
        test_op(2, 9, 18, 3);
`else
        test_op(5, 3, 15, 4);
        test_op(7, 0, 0, 1);
        test_op(7, 7, 49, 8);
        test_back_to_back();
        test_start_ignored();
        test_reset_mid_add();
`endif
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
